pool_out_fifo: RTL and testbench
================================

# pool_out_fifo

Downstream stage of the max-pooling block: captures each pooled byte presented with its valid strobe and buffers it in a small FIFO. It re-issues the bytes on a valid/ready stream with a per-frame last marker, so the next layer or DMA can apply backpressure that the pooler itself cannot. It also counts outputs per frame, checks the count against the pooler's end-of-frame strobe, and flags overflow and length errors.

## Interface
- DATA_W, 8, width of a pooled sample
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- OUT_COUNT, 16, pooled outputs per frame, i.e. (m/p)²; ≥ 1
- clk  in  1  single clock, rising edge
- master_rst_n  in  1  reset, asynchronous, active-low; clears all state
- in_data  in  DATA_W  pooled sample from the pooler's data_out
- in_valid  in  1  pooler valid_op; sample written when high
- in_end  in  1  pooler end_op; end-of-frame strobe
- out_data  out  DATA_W  head-of-FIFO sample
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- out_last  out  1  head sample is the final sample of its frame
- fifo_full  out  1  DEPTH entries held
- fill  out  clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a write was dropped
- len_err  out  1  sticky; in_end arrived with a partial frame count
- frame_done  out  1  one-cycle pulse when a last-tagged sample is popped

## Operation
- Storage: DEPTH × (DATA_W+1). The extra bit holds the last tag. Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in fill.
- push = in_valid & (!fifo_full | pop). pop = out_valid & out_ready.
- Full with simultaneous pop: the write is accepted and fill is unchanged.
- in_valid while full with no pop: the sample is dropped, overflow is set, and elem_cnt does not advance.
- Frame counter elem_cnt has range 0..OUT_COUNT-1. Each push stores tag = (elem_cnt == OUT_COUNT-1). On push, elem_cnt advances and wraps to 0 after OUT_COUNT-1.
- in_end handling: let cnt_eff = elem_cnt after any same-cycle push.
  - cnt_eff == 0: frame is consistent, no action.
  - cnt_eff ≠ 0: set len_err and force elem_cnt to 0. Samples already stored keep their tags; no retroactive last tag is added.
- frame_done = pop & out_last of the popped entry.
- overflow and len_err clear only on reset.
- Reset mid-frame: FIFO is emptied, pointers, fill and elem_cnt go to 0, and all sticky flags clear. Samples in flight are discarded.

## Timing
- Reset values: out_valid 0, out_last 0, out_data 0, fifo_full 0, fill 0, overflow 0, len_err 0, frame_done 0.
- Write latency: a sample pushed at edge t is visible with out_valid=1 after edge t (one cycle, first-word-fall-through). out_data and out_last follow the read pointer combinationally from storage.
- Pop at edge t: the next entry, if any, is presented after edge t. out_valid drops after t if fill was 1 with no push.
- Output handshake: out_data and out_last remain stable while out_valid & !out_ready.
- overflow and len_err rise the cycle after the offending edge.
- frame_done is registered. It is high during the cycle after the popping edge, for exactly one cycle per last-tagged pop.
- Throughput: one push and one pop per cycle sustained, including at full and empty.
- fill equals DEPTH exactly when fifo_full is high. fill never exceeds DEPTH.

## Test plan
- Reset/basic, DEPTH=16, OUT_COUNT=16, out_ready=1: push 16 samples 0x01..0x10 → same order out, one cycle latency, out_last only with 0x10, one frame_done pulse, flags 0.
- Backpressure: out_ready=0, push 16 → fifo_full=1, fill=16. Push 17th (0xAA) → dropped, overflow=1. Release ready → 16 original samples out, 0xAA absent, elem_cnt unaffected by the drop.
- Full with simultaneous pop: fill=16, in_valid & out_ready same cycle → write accepted, fill stays 16, overflow stays 0.
- Length error: OUT_COUNT=16, push 10 samples then in_end → len_err=1, no sample tagged last. Next 16 pushes → 16th tagged last.
- in_end coincident with 16th push → no len_err, last tag on that sample.
- Async reset mid-stream, fill=7 with overflow=1: assert master_rst_n low between edges → out_valid, fill and overflow 0 immediately. After release, a fresh frame behaves as in the first scenario.

Source files
------------

// File: rtl/pool_out_fifo_if.sv
// Stream bundle between the max-pooler, the output FIFO and the downstream consumer.
// Handshake: a sample moves on out_data exactly when out_valid & out_ready are both high at a rising edge.
interface pool_out_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_end;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    fifo_full;
  logic [$clog2(DEPTH):0]  fill;
  logic                    overflow;
  logic                    len_err;
  logic                    frame_done;

  modport master (
    output in_data, in_valid, in_end, out_ready,
    input  out_data, out_valid, out_last, fifo_full, fill, overflow, len_err, frame_done
  );

  modport slave (
    input  in_data, in_valid, in_end, out_ready,
    output out_data, out_valid, out_last, fifo_full, fill, overflow, len_err, frame_done
  );
endinterface

// File: rtl/pool_out_fifo.sv
// Output FIFO behind the max-pooler: buffers pooled bytes, tags frame ends,
// and flags dropped writes and frames whose length disagrees with the end strobe.
module pool_out_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int OUT_COUNT = 16
) (
  input logic            clk,
  input logic            master_rst_n,
  pool_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int EW = DATA_W + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;
  logic          overflow_q, overflow_d;
  logic          len_err_q, len_err_d;
  logic          frame_done_q, frame_done_d;

  logic          out_valid;
  logic          full;
  logic          push;
  logic          pop;
  logic          tag;
  logic [CW-1:0] cnt_eff;
  logic [EW-1:0] head;

  assign out_valid = (fill_q != '0);
  assign full      = (fill_q == FW'(DEPTH));
  assign pop       = out_valid & bus.out_ready;
  assign push      = bus.in_valid & (~full | pop);
  assign tag       = (elem_cnt_q == CW'(OUT_COUNT - 1));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q + FW'(push) - FW'(pop);
    overflow_d   = overflow_q | (bus.in_valid & ~push);
    len_err_d    = len_err_q;
    frame_done_d = pop & head[DATA_W];
    cnt_eff      = elem_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {tag, bus.in_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      cnt_eff         = tag ? '0 : elem_cnt_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A short frame is resynchronised at the end strobe; stored tags stay as written.
    elem_cnt_d = cnt_eff;
    if (bus.in_end && cnt_eff != '0) begin
      len_err_d  = 1'b1;
      elem_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      elem_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      len_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      elem_cnt_q   <= elem_cnt_d;
      overflow_q   <= overflow_d;
      len_err_q    <= len_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Head is gated so an empty FIFO presents zeros rather than stale storage.
  assign bus.out_data   = out_valid ? head[DATA_W-1:0] : '0;
  assign bus.out_last   = out_valid & head[DATA_W];
  assign bus.out_valid  = out_valid;
  assign bus.fifo_full  = full;
  assign bus.fill       = fill_q;
  assign bus.overflow   = overflow_q;
  assign bus.len_err    = len_err_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_out_fifo.sv
// Directed bench for pool_out_fifo: ordering, backpressure, full-with-pop,
// frame length checking and asynchronous reset.
module tb_pool_out_fifo;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int OUT_COUNT = 16;

  logic clk;
  logic master_rst_n;
  int   n_checks;
  int   n_pass;

  pool_out_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  pool_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_COUNT(OUT_COUNT)) dut (
    .clk          (clk),
    .master_rst_n (master_rst_n),
    .bus          (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at 1 ns after a rising edge; outputs are observed at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    master_rst_n = 1'b0;
    repeat (2) cycle();
    master_rst_n = 1'b1;
    cycle();
  endtask

  task automatic push_hold(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    master_rst_n = 1'b0;
    cycle();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", bus.out_last); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", bus.out_data); else n_pass++;
    n_checks++; if (bus.fifo_full !== 1'b0) $display("FAIL reset_fifo_full got %b exp 0", bus.fifo_full); else n_pass++;
    n_checks++; if (bus.fill !== 5'd0) $display("FAIL reset_fill got %0d exp 0", bus.fill); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", bus.overflow); else n_pass++;
    n_checks++; if (bus.len_err !== 1'b0) $display("FAIL reset_len_err got %b exp 0", bus.len_err); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", bus.frame_done); else n_pass++;
    master_rst_n = 1'b1;
    cycle();
  endtask

  // Streams 0x01..0x10 with the consumer always ready; each sample is the head one cycle after its push.
  task automatic test_basic(input string tag);
    logic [7:0] exp_d;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = 8'(i + 1);
      bus.in_data  = exp_d;
      bus.in_valid = 1'b1;
      cycle();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) $display("FAIL %s_data i=%0d got v=%b d=%h exp v=1 d=%h", tag, i, bus.out_valid, bus.out_data, exp_d); else n_pass++;
      n_checks++; if (bus.out_last !== (i == 15)) $display("FAIL %s_last i=%0d got %b exp %b", tag, i, bus.out_last, (i == 15)); else n_pass++;
      n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL %s_early_done i=%0d got %b exp 0", tag, i, bus.frame_done); else n_pass++;
    end
    bus.in_valid = 1'b0;
    cycle();
    n_checks++; if (bus.frame_done !== 1'b1) $display("FAIL %s_frame_done got %b exp 1", tag, bus.frame_done); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.fill !== 5'd0) $display("FAIL %s_drained got v=%b fill=%0d exp v=0 fill=0", tag, bus.out_valid, bus.fill); else n_pass++;
    cycle();
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL %s_done_pulse got %b exp 0", tag, bus.frame_done); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0 || bus.len_err !== 1'b0) $display("FAIL %s_flags got ovf=%b len=%b exp 0 0", tag, bus.overflow, bus.len_err); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_hold(8'(8'h20 + i));
    n_checks++; if (bus.fifo_full !== 1'b1 || bus.fill !== 5'd16) $display("FAIL bp_full got full=%b fill=%0d exp 1 16", bus.fifo_full, bus.fill); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL bp_no_ovf_yet got %b exp 0", bus.overflow); else n_pass++;
    push_hold(8'hAA);
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL bp_overflow got %b exp 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.fill !== 5'd16) $display("FAIL bp_fill_after_drop got %0d exp 16", bus.fill); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.out_data !== 8'(8'h20 + i) || bus.out_last !== (i == 15)) $display("FAIL bp_drain i=%0d got d=%h l=%b exp d=%h l=%b", i, bus.out_data, bus.out_last, 8'(8'h20 + i), (i == 15)); else n_pass++;
      cycle();
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b1) $display("FAIL bp_end got v=%b done=%b exp v=0 done=1", bus.out_valid, bus.frame_done); else n_pass++;
    // The dropped write must not have advanced the frame counter.
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(8'h30 + i);
      bus.in_valid = 1'b1;
      cycle();
      n_checks++; if (bus.out_data !== 8'(8'h30 + i) || bus.out_last !== (i == 15)) $display("FAIL bp_next_frame i=%0d got d=%h l=%b exp d=%h l=%b", i, bus.out_data, bus.out_last, 8'(8'h30 + i), (i == 15)); else n_pass++;
    end
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_hold(8'(8'h40 + i));
    n_checks++; if (bus.out_data !== 8'h40) $display("FAIL fp_head got %h exp 40", bus.out_data); else n_pass++;
    bus.in_data   = 8'h50;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.fill !== 5'd16 || bus.fifo_full !== 1'b1) $display("FAIL fp_fill got fill=%0d full=%b exp 16 1", bus.fill, bus.fifo_full); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL fp_overflow got %b exp 0", bus.overflow); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.out_data !== 8'(8'h41 + i) || bus.out_last !== (i == 14)) $display("FAIL fp_drain i=%0d got d=%h l=%b exp d=%h l=%b", i, bus.out_data, bus.out_last, 8'(8'h41 + i), (i == 14)); else n_pass++;
      cycle();
    end
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fp_empty got %b exp 0", bus.out_valid); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_len_err();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data  = 8'(8'h60 + i);
      bus.in_valid = 1'b1;
      cycle();
      n_checks++; if (bus.out_last !== 1'b0) $display("FAIL le_short_last i=%0d got %b exp 0", i, bus.out_last); else n_pass++;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.len_err !== 1'b0) $display("FAIL le_before_end got %b exp 0", bus.len_err); else n_pass++;
    bus.in_end = 1'b1;
    cycle();
    bus.in_end = 1'b0;
    n_checks++; if (bus.len_err !== 1'b1) $display("FAIL le_len_err got %b exp 1", bus.len_err); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL le_no_done got %b exp 0", bus.frame_done); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(8'h70 + i);
      bus.in_valid = 1'b1;
      cycle();
      n_checks++; if (bus.out_data !== 8'(8'h70 + i) || bus.out_last !== (i == 15)) $display("FAIL le_resync i=%0d got d=%h l=%b exp d=%h l=%b", i, bus.out_data, bus.out_last, 8'(8'h70 + i), (i == 15)); else n_pass++;
    end
    bus.in_valid = 1'b0;
    cycle();
    n_checks++; if (bus.len_err !== 1'b1) $display("FAIL le_sticky got %b exp 1", bus.len_err); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_end_coincident();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(8'h80 + i);
      bus.in_valid = 1'b1;
      bus.in_end   = (i == 15);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    n_checks++; if (bus.out_data !== 8'h8F || bus.out_last !== 1'b1) $display("FAIL ec_last got d=%h l=%b exp d=8f l=1", bus.out_data, bus.out_last); else n_pass++;
    n_checks++; if (bus.len_err !== 1'b0) $display("FAIL ec_len_err got %b exp 0", bus.len_err); else n_pass++;
    cycle();
    n_checks++; if (bus.len_err !== 1'b0 || bus.frame_done !== 1'b1) $display("FAIL ec_after got len=%b done=%b exp 0 1", bus.len_err, bus.frame_done); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) push_hold(8'(8'h90 + i));
    bus.out_ready = 1'b1;
    repeat (9) cycle();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.fill !== 5'd7 || bus.overflow !== 1'b1) $display("FAIL ar_setup got fill=%0d ovf=%b exp 7 1", bus.fill, bus.overflow); else n_pass++;
    #3;
    master_rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ar_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.fill !== 5'd0) $display("FAIL ar_fill got %0d exp 0", bus.fill); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL ar_overflow got %b exp 0", bus.overflow); else n_pass++;
    #2;
    master_rst_n = 1'b1;
    cycle();
    test_basic("ar_fresh");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    master_rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_basic("basic");
    test_backpressure();
    do_reset();
    test_full_pop();
    do_reset();
    test_len_err();
    do_reset();
    test_end_coincident();
    do_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
